jesd204b_rx_link_ctrl: RTL and testbench
========================================

# jesd204b_rx_link_ctrl

Link-layer controller placed directly downstream of the per-lane receive data paths. It drives the SYNC~ output to the transmitter and owns the subclass-1 LMFC counter, which it aligns to SYSREF. It drives the CGS/IFS resets to every lane and broadcasts a single buffer-release to all lanes' elastic buffers. The release is issued at a fixed LMFC offset so that all lanes leave their buffers on the same cycle, giving deterministic latency.

## Interface
- NUM_LANES, 2: number of lane data paths controlled.
- PARALLEL_OCTETS, 4: octets per lane per clock.
- OCTETS_PER_FRAME, 1: JESD F.
- FRAMES_PER_MF, 32: JESD K. K*F must be a multiple of PARALLEL_OCTETS.
- ILAS_TIMEOUT_MF, 8: number of multiframes allowed in ILAS before resync.
- LMFC_PERIOD (localparam), K*F/PARALLEL_OCTETS: clocks per multiframe. Defaults give 8.
- clk_i  in  1  link clock. One clock domain only.
- rst_i  in  1  synchronous, active-high reset.
- sysref_i  in  1  SYSREF, already synchronous to clk_i.
- cfg_rbd_i  in  $clog2(LMFC_PERIOD)  release-buffer delay in clocks, range 0..LMFC_PERIOD-1.
- cfg_sysref_oneshot_i  in  1  when 1, only the first SYSREF edge after reset realigns the LMFC.
- lane_cgs_detected_i  in  NUM_LANES  per-lane CGS detected.
- lane_ifs_start_i  in  NUM_LANES  per-lane IFS started. Status only; reported on all_ifs_o.
- lane_buffer_ready_ni  in  NUM_LANES  per-lane buffer ready, active low.
- cgs_reset_o  out  1  broadcast CGS reset to lanes, active high.
- ifs_reset_o  out  1  broadcast IFS reset to lanes, active high.
- buffer_release_no  out  1  broadcast elastic-buffer release, active low.
- sync_no  out  1  SYNC~ to transmitter, active low.
- lmfc_edge_o  out  1  one-cycle pulse when the LMFC count is 0.
- link_state_o  out  2  FSM state: 0 RESET, 1 CGS, 2 ILAS, 3 DATA.
- all_ifs_o  out  1  AND of lane_ifs_start_i, registered.
- sysref_misalign_o  out  1  sticky. Set when a SYSREF edge arrives off the current LMFC phase.

## Operation
- **LMFC counter** (lmfc_cnt)
  - Counts 0..LMFC_PERIOD-1 and wraps to 0.
  - lmfc_edge_o = (lmfc_cnt==0).
- **SYSREF edge**: sysref_i=1 while its previous-cycle sample was 0.
  - On an edge, if realignment is permitted, lmfc_cnt loads 0 on the next cycle.
  - Realignment is permitted when lmfc_valid=0, or when cfg_sysref_oneshot_i=0.
  - The first edge sets lmfc_valid.
- **Misalignment**: when lmfc_valid=1, an edge whose free-running next count would not be 0 sets sysref_misalign_o.
  - Oneshot mode applies the same check.
  - sysref_misalign_o clears only on rst_i.
- **FSM.** Outputs decode from the registered state only (Moore).
  - **RESET**
    - Outputs: cgs_reset_o=1, ifs_reset_o=1, sync_no=0, buffer_release_no=1.
    - Always moves to CGS after one cycle.
  - **CGS**
    - Outputs: cgs_reset_o=0, ifs_reset_o=1, sync_no=0, buffer_release_no=1.
    - Moves to ILAS when all lane_cgs_detected_i=1, lmfc_valid=1 and lmfc_cnt==LMFC_PERIOD-1. SYNC~ therefore rises on an LMFC boundary.
    - A lane dropping CGS in this state has no effect; the FSM waits.
  - **ILAS**
    - Outputs: ifs_reset_o=0, sync_no=1, buffer_release_no=1.
    - A timeout counter increments on each lmfc_edge_o and clears on entry to ILAS.
    - Moves to DATA when all lane_buffer_ready_ni=0 and lmfc_cnt==cfg_rbd_i.
  - **DATA**
    - Outputs: sync_no=1, buffer_release_no=0.
- **Return to RESET**
  - From ILAS or DATA: any lane_cgs_detected_i=0 forces RESET.
  - From ILAS: the timeout counter reaching ILAS_TIMEOUT_MF forces RESET.
- **Priority**: rst_i > CGS loss > timeout > advance.
- **SYSREF vs. transition check**: SYSREF realignment and an FSM transition in the same cycle are both applied. The FSM compares against the pre-realignment lmfc_cnt.
- **Released lane dropping ready**: a lane whose buffer_ready_ni returns to 1 while in DATA causes no action.

## Timing
- **Reset values** (after the rst_i cycle)
  - state=RESET, lmfc_cnt=0, lmfc_valid=0, timeout counter=0.
  - sync_no=0, cgs_reset_o=1, ifs_reset_o=1, buffer_release_no=1.
  - lmfc_edge_o=1 (cnt 0), link_state_o=0, all_ifs_o=0, sysref_misalign_o=0.
- **rst_i in any state**: takes effect at the next edge. It aborts ILAS/DATA immediately, and release returns to 1.
- **SYSREF latency**: edge detected in cycle n gives lmfc_cnt=0 and lmfc_edge_o=1 in cycle n+1.
- **State-change latency**: a transition condition true in cycle n changes state and outputs in cycle n+1.
  - CGS→ILAS: sync_no rises in a cycle where lmfc_cnt==0.
  - ILAS→DATA: buffer_release_no falls in the cycle where lmfc_cnt==cfg_rbd_i+1 (mod LMFC_PERIOD).
- **cfg_rbd_i**: sampled every cycle. Changing it outside ILAS has no effect. Values ≥ LMFC_PERIOD never match, so the timeout fires.
- **all_ifs_o**: one cycle latency.

## Test plan
- **Normal bring-up.** Defaults. Pulse sysref_i at cycle 10. Raise all CGS at cycle 20. Ready lanes at cycle 40. cfg_rbd_i=3.
  - lmfc_edge_o at cycle 11, then every 8 cycles.
  - sync_no rises on an LMFC-zero cycle.
  - buffer_release_no falls when lmfc_cnt==4.
  - link_state_o=3.
- **No SYSREF.** CGS on all lanes, no SYSREF pulse.
  - FSM stays in CGS with sync_no=0 indefinitely.
  - Pulsing SYSREF then advances the FSM on the next LMFC wrap.
- **ILAS timeout.** Lane 1 never ready.
  - After 8 lmfc_edge_o pulses in ILAS: state RESET for 1 cycle, then CGS, sync_no=0.
- **CGS loss in DATA.** In DATA, drop lane_cgs_detected_i[0].
  - Next cycle: RESET, buffer_release_no=1, sync_no=0, cgs_reset_o=1.
- **SYSREF misalignment, oneshot=1.** Second SYSREF pulse 3 cycles off phase.
  - lmfc_cnt is not realigned.
  - sysref_misalign_o=1 and stays 1 until rst_i.
  - With oneshot=0 the counter realigns and sysref_misalign_o also sets.
- **Reset mid-DATA.** Assert rst_i for 1 cycle.
  - All outputs return to their reset values on the next cycle.
  - The realignment and bring-up sequence repeat.

Source files
------------

// File: rtl/jesd204b_rx_link_ctrl.sv
// JESD204B receive link-layer controller: SYNC~ generation, subclass-1 LMFC alignment
// to SYSREF, and a single deterministic-latency elastic-buffer release to all lanes.
module jesd204b_rx_link_ctrl #(
    parameter int NUM_LANES        = 2,
    parameter int PARALLEL_OCTETS  = 4,
    parameter int OCTETS_PER_FRAME = 1,
    parameter int FRAMES_PER_MF    = 32,
    parameter int ILAS_TIMEOUT_MF  = 8,
    localparam int LMFC_PERIOD     = FRAMES_PER_MF * OCTETS_PER_FRAME / PARALLEL_OCTETS,
    localparam int CNT_W           = (LMFC_PERIOD > 1) ? $clog2(LMFC_PERIOD) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sysref_i,
    input  logic [CNT_W-1:0]     cfg_rbd_i,
    input  logic                 cfg_sysref_oneshot_i,
    input  logic [NUM_LANES-1:0] lane_cgs_detected_i,
    input  logic [NUM_LANES-1:0] lane_ifs_start_i,
    input  logic [NUM_LANES-1:0] lane_buffer_ready_ni,
    output logic                 cgs_reset_o,
    output logic                 ifs_reset_o,
    output logic                 buffer_release_no,
    output logic                 sync_no,
    output logic                 lmfc_edge_o,
    output logic [1:0]           link_state_o,
    output logic                 all_ifs_o,
    output logic                 sysref_misalign_o
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CGS   = 2'd1,
        ST_ILAS  = 2'd2,
        ST_DATA  = 2'd3
    } link_state_e;

    localparam int               TO_W      = $clog2(ILAS_TIMEOUT_MF + 1);
    localparam logic [CNT_W-1:0] LMFC_LAST = CNT_W'(LMFC_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(ILAS_TIMEOUT_MF);

    link_state_e      state_q;
    link_state_e      state_d;
    logic [CNT_W-1:0] lmfc_cnt;
    logic [CNT_W-1:0] lmfc_cnt_free;
    logic             lmfc_valid;
    logic             sysref_q;
    logic             sysref_edge;
    logic             realign_ok;
    logic [TO_W-1:0]  to_cnt;
    logic             to_expired;
    logic             all_cgs;
    logic             all_ready;

    assign sysref_edge   = sysref_i & ~sysref_q;
    assign realign_ok    = ~lmfc_valid | ~cfg_sysref_oneshot_i;
    assign lmfc_cnt_free = (lmfc_cnt == LMFC_LAST) ? '0 : lmfc_cnt + 1'b1;
    assign lmfc_edge_o   = (lmfc_cnt == '0);
    assign all_cgs       = &lane_cgs_detected_i;
    assign all_ready     = ~|lane_buffer_ready_ni;
    assign to_expired    = (to_cnt >= TO_LIMIT);
    assign link_state_o  = state_q;

    // LMFC counter, SYSREF alignment and the sticky off-phase SYSREF flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sysref_q          <= 1'b0;
            lmfc_cnt          <= '0;
            lmfc_valid        <= 1'b0;
            sysref_misalign_o <= 1'b0;
            all_ifs_o         <= 1'b0;
        end else begin
            sysref_q  <= sysref_i;
            all_ifs_o <= &lane_ifs_start_i;
            if (sysref_edge && realign_ok) begin
                lmfc_cnt <= '0;
            end else begin
                lmfc_cnt <= lmfc_cnt_free;
            end
            if (sysref_edge) begin
                lmfc_valid <= 1'b1;
                if (lmfc_valid && (lmfc_cnt_free != '0)) begin
                    sysref_misalign_o <= 1'b1;
                end
            end
        end
    end

    // Multiframes spent in ILAS; held at zero in every other state so entry starts clean.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != ST_ILAS)) begin
            to_cnt <= '0;
        end else if (lmfc_edge_o && !to_expired) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Transitions look at the registered lmfc_cnt, i.e. the phase before any same-cycle
    // SYSREF realignment takes effect.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_CGS;
            ST_CGS: begin
                if (all_cgs && lmfc_valid && (lmfc_cnt == LMFC_LAST)) begin
                    state_d = ST_ILAS;
                end
            end
            ST_ILAS: begin
                if (!all_cgs) begin
                    state_d = ST_RESET;
                end else if (to_expired) begin
                    state_d = ST_RESET;
                end else if (all_ready && (lmfc_cnt == cfg_rbd_i)) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!all_cgs) begin
                    state_d = ST_RESET;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        cgs_reset_o       = 1'b0;
        ifs_reset_o       = 1'b0;
        sync_no           = 1'b1;
        buffer_release_no = 1'b1;
        unique case (state_q)
            ST_RESET: begin
                cgs_reset_o = 1'b1;
                ifs_reset_o = 1'b1;
                sync_no     = 1'b0;
            end
            ST_CGS: begin
                ifs_reset_o = 1'b1;
                sync_no     = 1'b0;
            end
            ST_ILAS: begin
                sync_no = 1'b1;
            end
            ST_DATA: begin
                buffer_release_no = 1'b0;
            end
            default: begin
                cgs_reset_o = 1'b1;
                ifs_reset_o = 1'b1;
                sync_no     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jesd204b_rx_link_ctrl.sv
// Bench for jesd204b_rx_link_ctrl: directed bring-up scenarios plus randomized traffic,
// every cycle scored against a behavioural link model.
module tb_jesd204b_rx_link_ctrl;

    localparam int P  = 8;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sysref = 1'b0;
    logic       oneshot = 1'b1;
    logic [2:0] rbd = 3'd3;
    logic [1:0] cgs = 2'b00;
    logic [1:0] ifs = 2'b00;
    logic [1:0] rdy_n = 2'b11;

    logic       cgs_reset_o, ifs_reset_o, buffer_release_no, sync_no;
    logic       lmfc_edge_o, all_ifs_o, sysref_misalign_o;
    logic [1:0] link_state_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int align_cyc = 0;

    // behavioural model of the link
    int m_state = 0;
    int m_cnt = 0;
    int m_edges = 0;
    bit m_valid = 0;
    bit m_mis = 0;
    bit m_sref_q = 0;
    bit m_ifs = 0;

    logic [8:0] exp_q[$];

    jesd204b_rx_link_ctrl dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .sysref_i             (sysref),
        .cfg_rbd_i            (rbd),
        .cfg_sysref_oneshot_i (oneshot),
        .lane_cgs_detected_i  (cgs),
        .lane_ifs_start_i     (ifs),
        .lane_buffer_ready_ni (rdy_n),
        .cgs_reset_o          (cgs_reset_o),
        .ifs_reset_o          (ifs_reset_o),
        .buffer_release_no    (buffer_release_no),
        .sync_no              (sync_no),
        .lmfc_edge_o          (lmfc_edge_o),
        .link_state_o         (link_state_o),
        .all_ifs_o            (all_ifs_o),
        .sysref_misalign_o    (sysref_misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Advances the model by one clock using the inputs the DUT sampled at this edge.
    task automatic model_step();
        bit sref_edge;
        bit all_cgs;
        int free_cnt;
        int ns;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_edges = 0;
            m_valid = 0; m_mis = 0; m_sref_q = 0; m_ifs = 0;
        end else begin
            sref_edge = sysref && !m_sref_q;
            all_cgs   = (cgs == 2'b11);
            free_cnt  = (m_cnt + 1) % P;
            ns = m_state;
            case (m_state)
                0: ns = 1;
                1: if (all_cgs && m_valid && m_cnt == P - 1) ns = 2;
                2: begin
                    if (!all_cgs) ns = 0;
                    else if (m_edges >= TO) ns = 0;
                    else if (rdy_n == 2'b00 && m_cnt == int'(rbd)) ns = 3;
                end
                default: if (!all_cgs) ns = 0;
            endcase
            if (m_state != 2) m_edges = 0;
            else if (m_cnt == 0) m_edges++;
            if (sref_edge && m_valid && free_cnt != 0) m_mis = 1;
            m_cnt = (sref_edge && (!m_valid || !oneshot)) ? 0 : free_cnt;
            if (sref_edge) m_valid = 1;
            m_sref_q = sysref;
            m_ifs    = (ifs == 2'b11);
            m_state  = ns;
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [3:0] ctl;
        case (m_state)
            0:       ctl = 4'b0111;
            1:       ctl = 4'b0101;
            2:       ctl = 4'b1100;
            default: ctl = 4'b1000;
        endcase
        return {2'(m_state), ctl, (m_cnt == 0), m_ifs, m_mis};
    endfunction

    function automatic logic [8:0] dut_out();
        return {link_state_o, sync_no, buffer_release_no, cgs_reset_o, ifs_reset_o,
                lmfc_edge_o, all_ifs_o, sysref_misalign_o};
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            exp_q.push_back(model_out());
            #1;
            cyc++;
            check($sformatf("cycle%0d", cyc), 32'(dut_out()), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            if (link_state_o == s) ok = 1;
        end
    endtask

    task automatic bring_up(input logic [2:0] r);
        bit seen;
        cgs = 2'b00; rdy_n = 2'b11; sysref = 1'b0; oneshot = 1'b1; rbd = r;
        do_reset();
        tick(9);
        sysref = 1'b1;
        tick(1);
        sysref = 1'b0;
        align_cyc = cyc;
        check("sysref_latency", lmfc_edge_o, 1);
        tick(7);
        check("lmfc_mid", lmfc_edge_o, 0);
        tick(1);
        check("lmfc_period", lmfc_edge_o, 1);
        tick(1);
        cgs = 2'b11;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (sync_no) seen = 1;
        end
        check("sync_rise", seen, 1);
        check("sync_at_lmfc0", lmfc_edge_o, 1);
        check("sync_phase", (cyc - align_cyc) % P, 0);
        rdy_n = 2'b00;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (!buffer_release_no) seen = 1;
        end
        check("release_fall", seen, 1);
        check("release_phase", (cyc - align_cyc) % P, (int'(r) + 1) % P);
        check("data_state", link_state_o, 3);
    endtask

    initial begin
        bit ok;
        int edges;

        // reset values
        do_reset();
        check("rst_state", link_state_o, 0);
        check("rst_sync", sync_no, 0);
        check("rst_release", buffer_release_no, 1);
        check("rst_cgs_reset", cgs_reset_o, 1);
        check("rst_ifs_reset", ifs_reset_o, 1);
        check("rst_lmfc_edge", lmfc_edge_o, 1);
        check("rst_all_ifs", all_ifs_o, 0);
        check("rst_misalign", sysref_misalign_o, 0);

        // normal bring-up, then CGS loss in DATA
        bring_up(3'd3);
        cgs = 2'b10;
        tick(1);
        check("cgsloss_state", link_state_o, 0);
        check("cgsloss_release", buffer_release_no, 1);
        check("cgsloss_sync", sync_no, 0);
        check("cgsloss_cgs_reset", cgs_reset_o, 1);
        cgs = 2'b11;
        tick(20);

        // reset mid-DATA, then the sequence repeats
        bring_up(3'($urandom_range(0, 7)));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rstdata_state", link_state_o, 0);
        check("rstdata_release", buffer_release_no, 1);
        check("rstdata_sync", sync_no, 0);
        check("rstdata_edge", lmfc_edge_o, 1);
        bring_up(3'($urandom_range(0, 7)));

        // ILAS timeout with lane 1 never ready
        cgs = 2'b00; rdy_n = 2'b11; sysref = 1'b0; oneshot = 1'b1;
        do_reset();
        tick(3);
        sysref = 1'b1;
        tick(1);
        sysref = 1'b0;
        cgs = 2'b11;
        rdy_n = 2'b10;
        wait_state(2'd2, 30, ok);
        check("to_ilas_entry", ok, 1);
        edges = 0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (link_state_o == 2'd2 && lmfc_edge_o) edges++;
            tick(1);
            if (link_state_o != 2'd2) ok = 1;
        end
        check("to_left_ilas", ok, 1);
        check("to_reset_state", link_state_o, 0);
        check("to_edge_count", edges, TO);
        tick(1);
        check("to_cgs_state", link_state_o, 1);
        check("to_sync_low", sync_no, 0);

        // no SYSREF: parked in CGS until one arrives
        cgs = 2'b11; rdy_n = 2'b00; sysref = 1'b0;
        do_reset();
        tick(40);
        check("nosysref_state", link_state_o, 1);
        check("nosysref_sync", sync_no, 0);
        sysref = 1'b1;
        tick(1);
        sysref = 1'b0;
        wait_state(2'd2, 12, ok);
        check("nosysref_advance", ok, 1);
        check("nosysref_lmfc0", lmfc_edge_o, 1);

        // misalignment with oneshot=1
        cgs = 2'b00; rdy_n = 2'b11; oneshot = 1'b1;
        do_reset();
        tick(2);
        sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(7);
        sysref = 1'b1; tick(1); sysref = 1'b0;
        check("aligned_pulse_mis", sysref_misalign_o, 0);
        check("aligned_pulse_edge", lmfc_edge_o, 1);
        tick(2);
        sysref = 1'b1; tick(1); sysref = 1'b0;
        check("oneshot_mis", sysref_misalign_o, 1);
        check("oneshot_no_realign", lmfc_edge_o, 0);
        tick(5);
        check("oneshot_phase_kept", lmfc_edge_o, 1);
        tick(20);
        check("mis_sticky", sysref_misalign_o, 1);
        do_reset();
        check("mis_cleared", sysref_misalign_o, 0);

        // misalignment with oneshot=0
        oneshot = 1'b0;
        tick(2);
        sysref = 1'b1; tick(1); sysref = 1'b0;
        tick(2);
        sysref = 1'b1; tick(1); sysref = 1'b0;
        check("cont_realign", lmfc_edge_o, 1);
        check("cont_mis", sysref_misalign_o, 1);

        // randomized traffic
        cgs = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 599) == 0);
            sysref = ($urandom_range(0, 29) == 0);
            ifs    = 2'($urandom);
            if ($urandom_range(0, 199) == 0) cgs = 2'($urandom);
            else if ($urandom_range(0, 9) == 0) cgs = 2'b11;
            if ($urandom_range(0, 19) == 0) rdy_n = 2'($urandom);
            if ($urandom_range(0, 99) == 0) rbd = 3'($urandom);
            if ($urandom_range(0, 299) == 0) oneshot = ~oneshot;
            tick(1);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
